// File: rtl/commit_perf_monitor.sv
// Commit-stage performance monitor: counts run cycles, micro-ops and RISC-V ops, and flags goal/timeout end conditions.
// Optional COMMIT_PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module commit_perf_monitor #(
  parameter int unsigned COMMIT_WIDTH   = 2,
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned GOAL_CMP_WIDTH = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             clear,
  input  logic [COMMIT_WIDTH-1:0]          commit,
  input  logic [COMMIT_WIDTH-1:0]          commitFirstMop,
  input  logic [COMMIT_WIDTH*PC_WIDTH-1:0] commitPC,
  input  logic                             goalEnable,
  input  logic [PC_WIDTH-1:0]              goalPC,
  input  logic [CNT_WIDTH-1:0]             maxCycles,
  output logic [CNT_WIDTH-1:0]             cycleCount,
  output logic [CNT_WIDTH-1:0]             microOpCount,
  output logic [CNT_WIDTH-1:0]             riscvOpCount,
  output logic [PC_WIDTH-1:0]              lastCommittedPC,
  output logic                             goalReached,
  output logic                             timeout,
  output logic                             done
);

  localparam int unsigned LANE_W = $clog2(COMMIT_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, GOAL, TIMEOUT} state_t;

  state_t                 state;
  logic [LANE_W-1:0]      mop_cnt;
  logic [LANE_W-1:0]      rv_cnt;
  logic                   any_commit;
  logic                   goal_hit;
  logic [PC_WIDTH-1:0]    last_pc_c;
  logic [CNT_WIDTH-1:0]   cycle_next;
  logic                   timeout_hit;
  logic                   unused_goal_hi;

  // Only the low goal bits take part in the compare.
  assign unused_goal_hi = ^goalPC[PC_WIDTH-1:GOAL_CMP_WIDTH];

  function automatic logic [CNT_WIDTH-1:0] cnt_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
`ifdef COMMIT_PERF_SATURATE_EN
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  // Per-cycle lane reduction: popcounts, highest committing PC, goal match.
  always_comb begin
    mop_cnt    = '0;
    rv_cnt     = '0;
    any_commit = 1'b0;
    goal_hit   = 1'b0;
    last_pc_c  = lastCommittedPC;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit[i]) begin
        mop_cnt    = mop_cnt + LANE_W'(1);
        any_commit = 1'b1;
        last_pc_c  = commitPC[i*PC_WIDTH +: PC_WIDTH];
        if (commitFirstMop[i]) rv_cnt = rv_cnt + LANE_W'(1);
        if (goalEnable && (commitPC[i*PC_WIDTH +: GOAL_CMP_WIDTH] == goalPC[GOAL_CMP_WIDTH-1:0]))
          goal_hit = 1'b1;
      end
    end
  end

  assign cycle_next  = cnt_add(cycleCount, CNT_WIDTH'(1));
  assign timeout_hit = (maxCycles != '0) && (cycle_next == maxCycles);
  assign done        = (state == GOAL) || (state == TIMEOUT);

  // State and counters; clear overrides everything except reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cycleCount      <= '0;
      microOpCount    <= '0;
      riscvOpCount    <= '0;
      lastCommittedPC <= '0;
      goalReached     <= 1'b0;
      timeout         <= 1'b0;
    end else if (clear) begin
      state           <= IDLE;
      cycleCount      <= '0;
      microOpCount    <= '0;
      riscvOpCount    <= '0;
      lastCommittedPC <= '0;
      goalReached     <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          cycleCount   <= cycle_next;
          microOpCount <= cnt_add(microOpCount, CNT_WIDTH'(mop_cnt));
          riscvOpCount <= cnt_add(riscvOpCount, CNT_WIDTH'(rv_cnt));
          if (any_commit) lastCommittedPC <= last_pc_c;
          // Goal takes precedence when both end conditions land together.
          if (goal_hit) begin
            goalReached <= 1'b1;
            state       <= GOAL;
          end else if (timeout_hit) begin
            timeout <= 1'b1;
            state   <= TIMEOUT;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_perf_monitor.sv
// Scoreboard bench for commit_perf_monitor: a behavioural model queues expected outputs per edge, a monitor compares them.
module tb_commit_perf_monitor;

  localparam logic [63:0] MAXV = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, start, clear, goal_en;
  logic [1:0]  commit, fm;
  logic [63:0] cpc;
  logic [31:0] goal_pc, max_cycles;
  logic [31:0] cyc, mop, rv, lpc;
  logic        goal_r, to_r, done;

  // Narrow instance for the counter overflow case.
  logic        d2_start, d2_clear, d2_goal_en;
  logic [1:0]  d2_commit, d2_fm;
  logic [63:0] d2_pc;
  logic [31:0] d2_goal_pc;
  logic [3:0]  d2_max, d2_cyc, d2_mop, d2_rv;
  logic [31:0] d2_lpc;
  logic        d2_goal_r, d2_to_r, d2_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] cyc, mop, rv, pc;
    logic        g, t, d;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  bit              m_run, m_goal, m_to;
  longint unsigned m_cyc, m_mop, m_rv;
  logic [31:0]     m_pc;

  commit_perf_monitor dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .commit(commit), .commitFirstMop(fm), .commitPC(cpc),
    .goalEnable(goal_en), .goalPC(goal_pc), .maxCycles(max_cycles),
    .cycleCount(cyc), .microOpCount(mop), .riscvOpCount(rv),
    .lastCommittedPC(lpc), .goalReached(goal_r), .timeout(to_r), .done(done)
  );

  commit_perf_monitor #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(d2_start), .clear(d2_clear),
    .commit(d2_commit), .commitFirstMop(d2_fm), .commitPC(d2_pc),
    .goalEnable(d2_goal_en), .goalPC(d2_goal_pc), .maxCycles(d2_max),
    .cycleCount(d2_cyc), .microOpCount(d2_mop), .riscvOpCount(d2_rv),
    .lastCommittedPC(d2_lpc), .goalReached(d2_goal_r), .timeout(d2_to_r), .done(d2_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint unsigned madd(input longint unsigned a, input longint unsigned b);
    longint unsigned s;
    s = a + b;
`ifdef COMMIT_PERF_SATURATE_EN
    return (s > MAXV) ? MAXV : s;
`else
    return s & MAXV;
`endif
  endfunction

  task automatic model_zero();
    m_run = 0; m_goal = 0; m_to = 0;
    m_cyc = 0; m_mop = 0; m_rv = 0; m_pc = '0;
  endtask

  // Effect of one clock edge given the inputs currently applied.
  task automatic model_step();
    int  n, nf;
    bit  hit;
    if (rst || clear) begin
      model_zero();
    end else if (!m_run && !m_goal && !m_to) begin
      if (start) m_run = 1;
    end else if (m_run) begin
      n = 0; nf = 0; hit = 0;
      for (int i = 0; i < 2; i++) begin
        if (commit[i]) begin
          n++;
          if (fm[i]) nf++;
          m_pc = cpc[i*32 +: 32];
          if (goal_en && cpc[i*32 +: 16] == goal_pc[15:0]) hit = 1;
        end
      end
      m_cyc = madd(m_cyc, 1);
      m_mop = madd(m_mop, longint'(n));
      m_rv  = madd(m_rv, longint'(nf));
      if (hit) begin
        m_goal = 1; m_run = 0;
      end else if (max_cycles != 0 && m_cyc[31:0] == max_cycles) begin
        m_to = 1; m_run = 0;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e.cyc = m_cyc[31:0]; e.mop = m_mop[31:0]; e.rv = m_rv[31:0]; e.pc = m_pc;
    e.g = m_goal; e.t = m_to; e.d = m_goal || m_to;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    start = 0; clear = 0; commit = '0; fm = '0;
  endtask

  function automatic logic [31:0] pc_nomatch();
    logic [31:0] p;
    p = $urandom;
    if (p[15:0] == goal_pc[15:0]) p[0] = ~p[0];
    return p;
  endfunction

  function automatic logic [31:0] pc_small();
    logic [31:0] p;
    p = $urandom;
    p[15:0] = 16'($urandom_range(0, 47));
    return p;
  endfunction

  // Monitor: compares the queued expectation against the DUT away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cycleCount", cyc, e.cyc);
      chk("microOpCount", mop, e.mop);
      chk("riscvOpCount", rv, e.rv);
      chk("lastCommittedPC", lpc, e.pc);
      chk("goalReached", 32'(goal_r), 32'(e.g));
      chk("timeout", 32'(to_r), 32'(e.t));
      chk("done", 32'(done), 32'(e.d));
    end
  end

  initial begin
    int wait_cnt;
    idle_inputs();
    cpc = '0; goal_en = 0; goal_pc = '0; max_cycles = '0;
    d2_start = 0; d2_clear = 0; d2_goal_en = 0; d2_commit = '0; d2_fm = '0;
    d2_pc = '0; d2_goal_pc = '0; d2_max = '0;
    rst = 1;
    model_zero();
    #12;
    chk("reset_cyc", cyc, 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    tick();
    rst = 0;

    // Basic counting: 10 RUN cycles, both lanes commit, lane0 first-mop.
    start = 1; tick(); start = 0;
    for (int i = 0; i < 10; i++) begin
      commit = 2'b11; fm = 2'b01; cpc = {pc_nomatch(), pc_nomatch()};
      tick();
    end
    chk("basic_cyc", cyc, 32'd10);
    chk("basic_mop", mop, 32'd20);
    chk("basic_rv", rv, 32'd10);
    chk("basic_done", 32'(done), 32'd0);

    // Goal on lane 1 in RUN cycle 5, then frozen.
    idle_inputs(); clear = 1; tick(); clear = 0;
    goal_en = 1; goal_pc = 32'h0000_1234;
    start = 1; tick(); start = 0;
    for (int i = 1; i <= 8; i++) begin
      commit = (i == 5) ? 2'b10 : 2'($urandom_range(0, 3));
      fm = 2'($urandom_range(0, 3));
      cpc = (i == 5) ? {32'h8000_1234, pc_nomatch()} : {pc_nomatch(), pc_nomatch()};
      if (i > 5) cpc = {32'h0000_1234, 32'h0000_1234};
      tick();
      if (i == 5) begin
        chk("goal_reached", 32'(goal_r), 32'd1);
        chk("goal_cyc", cyc, 32'd5);
        chk("goal_pc", lpc, 32'h8000_1234);
      end
    end
    chk("goal_frozen_cyc", cyc, 32'd5);

    // Timeout after 3 cycles, no commits.
    idle_inputs(); clear = 1; tick(); clear = 0;
    goal_en = 0; max_cycles = 32'd3;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("to_flag", 32'(to_r), 32'd1);
    chk("to_cyc", cyc, 32'd3);
    chk("to_done", 32'(done), 32'd1);

    // Goal and timeout together: goal wins.
    clear = 1; tick(); clear = 0;
    goal_en = 1; goal_pc = 32'hABCD_0042;
    start = 1; tick(); start = 0;
    for (int i = 1; i <= 4; i++) begin
      commit = (i == 3) ? 2'b01 : 2'b00;
      cpc = (i == 3) ? {pc_nomatch(), 32'h7777_0042} : {pc_nomatch(), pc_nomatch()};
      tick();
    end
    chk("both_goal", 32'(goal_r), 32'd1);
    chk("both_to", 32'(to_r), 32'd0);

    // clear and start together in GOAL: IDLE with zero counters, then start -> RUN.
    idle_inputs(); clear = 1; start = 1; tick(); clear = 0; start = 0;
    chk("clr_cyc", cyc, 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    commit = 2'b01; cpc = {pc_nomatch(), pc_nomatch()}; tick();
    chk("clr_idle_mop", mop, 32'd0);
    start = 1; tick(); start = 0; tick();
    chk("clr_restart_cyc", cyc, 32'd1);

    // Randomized runs with small PC alphabet so goals and timeouts both occur.
    for (int r = 0; r < 10; r++) begin
      idle_inputs(); clear = 1; tick(); clear = 0;
      goal_en = 1'($urandom_range(0, 1));
      goal_pc = pc_small();
      max_cycles = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(5, 60));
      commit = 2'($urandom_range(0, 3)); cpc = {pc_small(), pc_small()};
      start = 1; tick(); start = 0;
      for (int c = 0; c < 120 && !(m_goal || m_to); c++) begin
        commit = 2'($urandom_range(0, 3)); fm = 2'($urandom_range(0, 3));
        cpc = {pc_small(), pc_small()};
        start = ($urandom_range(0, 7) == 0);
        tick();
      end
      for (int c = 0; c < 3; c++) begin
        commit = 2'($urandom_range(0, 3)); cpc = {pc_small(), pc_small()}; start = 1;
        tick();
      end
    end

    // Asynchronous reset between edges mid-RUN.
    idle_inputs(); clear = 1; tick(); clear = 0;
    goal_en = 0; max_cycles = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 4; i++) begin
      commit = 2'b11; fm = 2'b11; cpc = {pc_nomatch(), pc_nomatch()}; tick();
    end
    @(negedge clk); #1;
    rst = 1; #1;
    chk("arst_cyc", cyc, 32'd0);
    chk("arst_mop", mop, 32'd0);
    chk("arst_pc", lpc, 32'd0);
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("arst_idle_mop", mop, 32'd0);
    start = 1; tick(); start = 0; tick();
    chk("arst_restart_mop", mop, 32'd2);

    // 4-bit counters: 14 single commits then a double commit.
    idle_inputs();
    d2_start = 1; @(posedge clk); #1; d2_start = 0;
    d2_commit = 2'b01;
    for (int i = 0; i < 14; i++) begin @(posedge clk); #1; end
    chk("w4_pre", 32'(d2_mop), 32'd14);
    d2_commit = 2'b11;
    @(posedge clk); #1;
    d2_commit = 2'b00;
`ifdef COMMIT_PERF_SATURATE_EN
    chk("w4_sat", 32'(d2_mop), 32'd15);
`else
    chk("w4_wrap", 32'(d2_mop), 32'd0);
`endif

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin @(posedge clk); wait_cnt++; end
    if (exp_q.size() > 0) chk("queue_drain", 32'(exp_q.size()), 32'd0);
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_perf_monitor.md
Name: commit_perf_monitor

Overview:
- Synthesizable in-core monitor on the commit stage's retire lanes.
- Counts committed micro-ops and RISC-V ops and elapsed run cycles, and tracks the last committed PC.
- Detects the PC-goal and max-cycle end conditions.
- Supplies the simulation bench and the debug register with final counts and a done indication, so the bench no longer re-derives them each cycle.

Parameters:
- COMMIT_WIDTH, 2, number of commit lanes.
- PC_WIDTH, 32, committed PC width.
- GOAL_CMP_WIDTH, 16, low PC bits compared against the goal (matches LED width).
- CNT_WIDTH, 32, width of every counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse; arms monitor (IDLE->RUN).
- clear  in  1  synchronous; zeroes counters and returns to IDLE.
- commit  in  COMMIT_WIDTH  per-lane commit valid.
- commitFirstMop  in  COMMIT_WIDTH  per-lane flag: micro-op id mid==0.
- commitPC  in  COMMIT_WIDTH*PC_WIDTH  per-lane PC, lane i at bits [i*PC_WIDTH +: PC_WIDTH].
- goalEnable  in  1  enables PC-goal termination.
- goalPC  in  PC_WIDTH  goal PC; only the low GOAL_CMP_WIDTH bits are used.
- maxCycles  in  CNT_WIDTH  cycle limit; 0 = unlimited.
- cycleCount  out  CNT_WIDTH  RUN cycles elapsed.
- microOpCount  out  CNT_WIDTH  committed micro-ops.
- riscvOpCount  out  CNT_WIDTH  committed RISC-V ops.
- lastCommittedPC  out  PC_WIDTH  PC of the highest-index committing lane in the latest commit cycle.
- goalReached  out  1  sticky; goal hit.
- timeout  out  1  sticky; maxCycles hit.
- done  out  1  state is GOAL or TIMEOUT.

Behaviour:
- Reset (async, rst=1): all counters 0, lastCommittedPC 0, goalReached/timeout/done 0, state IDLE.
  - Reset mid-RUN discards everything immediately, with no wait for a clock edge.
- States:
  - IDLE: counters hold, commits ignored. start -> RUN.
  - RUN: counting active. Exits: goal -> GOAL; timeout -> TIMEOUT.
  - GOAL and TIMEOUT: terminal. All outputs frozen; only clear or rst leave them.
- clear has priority over start and over every RUN update. clear -> IDLE with counters 0 next cycle.
- Per RUN cycle (all registered, 1-cycle latency from inputs to outputs):
  - cycleCount += 1.
  - microOpCount += popcount(commit).
  - riscvOpCount += popcount(commit & commitFirstMop).
  - Non-contiguous commit vectors are counted as given (plain popcount).
- lastCommittedPC: updated when any commit bit is set, to the PC of the highest set lane. Held otherwise.
- Goal hit: goalEnable=1 and any committing lane has PC[GOAL_CMP_WIDTH-1:0] == goalPC[GOAL_CMP_WIDTH-1:0].
  - That cycle's commits are still counted, and cycleCount includes that cycle.
  - goalReached=1, state=GOAL, both visible the next cycle.
- Timeout: maxCycles!=0 and the incremented cycleCount == maxCycles.
  - That cycle counts normally; next cycle timeout=1, state=TIMEOUT.
- Goal and timeout in the same cycle: GOAL wins, goalReached=1, timeout stays 0.
- done = (state==GOAL)||(state==TIMEOUT), registered-state decode.
- Wrap-around: counters wrap modulo 2^CNT_WIDTH (see optional feature). maxCycles compare uses the wrapped value.
- start while in RUN/GOAL/TIMEOUT: ignored.
- Commits in IDLE: not counted, and lastCommittedPC is not updated.

Optional Feature:
- Macro: COMMIT_PERF_SATURATE_EN.
- Defined: each counter saturates at 2^CNT_WIDTH-1 and holds. An add that would overflow clamps to max. Timeout still fires if max equals maxCycles.
- Undefined: counters wrap modulo 2^CNT_WIDTH.

Test Plan:
- Reset then start, 10 RUN cycles with commit=2'b11, commitFirstMop=2'b01 -> cycleCount=10, microOpCount=20, riscvOpCount=10, done=0.
- goalEnable=1, goalPC=0x0000_1234; lane1 commits PC 0x8000_1234 in RUN cycle 5 -> next cycle goalReached=1, done=1, cycleCount=5, lastCommittedPC=0x8000_1234. Further commits leave counts unchanged.
- maxCycles=3, no commits -> after 3 RUN cycles timeout=1, cycleCount=3, done=1. Goal match on cycle 3 instead -> goalReached=1, timeout=0.
- rst asserted asynchronously between edges during RUN with counts nonzero -> all outputs 0 immediately. State IDLE; subsequent commits are not counted until start.
- clear and start asserted together in GOAL -> IDLE, counters 0. A later start -> RUN.
- CNT_WIDTH=4, preload 14 via 14 single commits, then commit=2'b11 -> microOpCount=0 without the macro, 15 with COMMIT_PERF_SATURATE_EN.
